// File: rtl/watch_pkg.sv
// watch_pkg
// Shared definitions for the watch front-end button controller:
//   - rep_state_t : states of the up/down auto-repeat machine
//   - SYNC_STAGES : depth of the per-button input synchroniser
//   - DEF_*       : default timing parameters (in clock cycles)
//   - BTN_*       : bit positions of the four buttons in packed vectors
//   - max_int     : helper used to size the shared repeat timer
package watch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } rep_state_t;

    localparam int SYNC_STAGES = 2;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_RATE     = 16;

    localparam int BTN_MODE = 0;
    localparam int BTN_SEL  = 1;
    localparam int BTN_UP   = 2;
    localparam int BTN_DOWN = 3;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronises one raw asynchronous button and debounces it. The debounced
// level only changes after DEBOUNCE_CYCLES consecutive synchronised samples
// disagree with it; a rising change of the debounced level is flagged for
// exactly one cycle on 'rise'.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   btn   in  raw asynchronous button level
//   level out debounced button level
//   rise  out one-cycle flag, high in the cycle after level rose
module btn_debounce
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   level_r;
    logic                   rise_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign level  = level_r;
    assign rise   = rise_r;

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
        end
    end

    // Stability counter: the level flips on the last of DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            if (sync_s == level_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync_s;
                cnt_r   <= CNT_ZERO;
                rise_r  <= sync_s;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/watch_keypad.sv
// watch_keypad
// Button front end for the settable 24-hour watch. Debounces four raw
// buttons and issues single-cycle command pulses. Up/down auto-repeat
// while held; pressing the opposite direction locks both out until
// both are released. At most one output is high per cycle, with
// priority mode > sel > inc/dec; a lower-priority event is dropped.
// Ports:
//   clk                                 in  clock shared with the watch core
//   rst                                 in  synchronous active-high reset
//   btn_mode, btn_sel, btn_up, btn_down in  raw asynchronous buttons
//   mode, sel, inc, dec                 out registered one-cycle commands
module watch_keypad
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_mode,
    input  logic btn_sel,
    input  logic btn_up,
    input  logic btn_down,
    output logic mode,
    output logic sel,
    output logic inc,
    output logic dec
);

    localparam int TMR_W = max_int($clog2(REPEAT_DELAY), $clog2(REPEAT_RATE)) + 1;
    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    logic [3:0]       raw_s;
    logic [3:0]       level_s;
    logic [3:0]       rise_s;
    logic             cmd_free_s;
    logic             own_level_s;
    logic             opp_level_s;
    rep_state_t       state_r;
    logic [TMR_W-1:0] timer_r;
    logic             dir_r;     // 0: up/inc latched, 1: down/dec latched

    assign raw_s = {btn_down, btn_up, btn_sel, btn_mode};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .btn  (raw_s[i]),
            .level(level_s[i]),
            .rise (rise_s[i])
        );
    end

    // inc/dec may only drive the outputs when mode and sel are quiet.
    assign cmd_free_s  = ~rise_s[BTN_MODE] & ~rise_s[BTN_SEL];
    assign own_level_s = dir_r ? level_s[BTN_DOWN] : level_s[BTN_UP];
    assign opp_level_s = dir_r ? level_s[BTN_UP]   : level_s[BTN_DOWN];

    // Repeat FSM, shared timer and prioritised output registers. The FSM
    // advances identically whether or not its pulse wins the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= TMR_ZERO;
            dir_r   <= 1'b0;
            mode    <= 1'b0;
            sel     <= 1'b0;
            inc     <= 1'b0;
            dec     <= 1'b0;
        end else begin
            mode <= rise_s[BTN_MODE];
            sel  <= rise_s[BTN_SEL] & ~rise_s[BTN_MODE];
            inc  <= 1'b0;
            dec  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s[BTN_UP] && rise_s[BTN_DOWN]) begin
                        state_r <= ST_LOCK;
                    end else if (rise_s[BTN_UP] && !level_s[BTN_DOWN]) begin
                        state_r <= ST_DELAY;
                        timer_r <= DELAY_LOAD;
                        dir_r   <= 1'b0;
                        inc     <= cmd_free_s;
                    end else if (rise_s[BTN_DOWN] && !level_s[BTN_UP]) begin
                        state_r <= ST_DELAY;
                        timer_r <= DELAY_LOAD;
                        dir_r   <= 1'b1;
                        dec     <= cmd_free_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (opp_level_s) begin
                        state_r <= ST_LOCK;
                    end else if (!own_level_s) begin
                        state_r <= ST_IDLE;
                    end else if (timer_r == TMR_ZERO) begin
                        state_r <= ST_REPEAT;
                        timer_r <= RATE_LOAD;
                        inc     <= cmd_free_s & ~dir_r;
                        dec     <= cmd_free_s & dir_r;
                    end else begin
                        timer_r <= timer_r - TMR_ONE;
                    end
                end
                ST_LOCK: begin
                    if (!level_s[BTN_UP] && !level_s[BTN_DOWN]) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOCK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watch_keypad.sv
// tb_watch_keypad
// Self-checking bench for watch_keypad (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=3). A behavioural model predicts every output cycle; directed
// scenarios additionally check pulse edges against fixed expected numbers.
// Edge k of a scenario is the k-th rising clock edge after the scenario
// starts; inputs set before step k are sampled at edge k.
module tb_watch_keypad;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn_mode, btn_sel, btn_up, btn_down;
    logic mode, sel, inc, dec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    watch_keypad #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_sel (btn_sel),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .mode    (mode),
        .sel     (sel),
        .inc     (inc),
        .dec     (dec)
    );

    // Reference model state. Buttons: 0 mode, 1 sel, 2 up, 3 down.
    bit m_h1 [4];
    bit m_h2 [4];
    bit m_deb [4];
    bit m_rise [4];
    int m_run [4];
    bit m_active, m_dir, m_lock;
    int m_t0;
    int m_g = 0;
    bit e_mode, e_sel, e_inc, e_dec;

    // Model of one clock edge: repeat pulses follow from elapsed time since the press.
    task automatic model_edge();
        bit raw [4];
        bit pulse;
        bit own, opp;
        int d;
        raw[0] = btn_mode; raw[1] = btn_sel; raw[2] = btn_up; raw[3] = btn_down;
        m_g++;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_h1[i] = 0; m_h2[i] = 0; m_deb[i] = 0; m_rise[i] = 0; m_run[i] = 0;
            end
            m_active = 0; m_lock = 0; m_dir = 0;
            e_mode = 0; e_sel = 0; e_inc = 0; e_dec = 0;
        end else begin
            pulse = 0;
            if (m_lock) begin
                if (!m_deb[2] && !m_deb[3]) m_lock = 0;
            end else if (m_active) begin
                own = m_dir ? m_deb[3] : m_deb[2];
                opp = m_dir ? m_deb[2] : m_deb[3];
                if (opp) begin
                    m_lock = 1; m_active = 0;
                end else if (!own) begin
                    m_active = 0;
                end else begin
                    d = m_g - m_t0;
                    pulse = (d == RD) || (d > RD && ((d - RD) % RR) == 0);
                end
            end else if (m_rise[2] && m_rise[3]) begin
                m_lock = 1;
            end else if (m_rise[2] && !m_deb[3]) begin
                m_active = 1; m_dir = 0; m_t0 = m_g; pulse = 1;
            end else if (m_rise[3] && !m_deb[2]) begin
                m_active = 1; m_dir = 1; m_t0 = m_g; pulse = 1;
            end
            e_mode = m_rise[0];
            e_sel  = m_rise[1] && !m_rise[0];
            e_inc  = pulse && !m_dir && !m_rise[0] && !m_rise[1];
            e_dec  = pulse && m_dir && !m_rise[0] && !m_rise[1];
            // debounced level flips once D consecutive synchronised samples disagree
            for (int i = 0; i < 4; i++) begin
                m_rise[i] = 0;
                if (m_h2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_deb[i] = m_h2[i]; m_run[i] = 0; m_rise[i] = m_h2[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_h2[i] = m_h1[i];
                m_h1[i] = raw[i];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_btns(input bit m, input bit s, input bit u, input bit d);
        btn_mode = m; btn_sel = s; btn_up = u; btn_down = d;
    endtask

    task automatic settle(input int n);
        set_btns(0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 1; k <= n; k++) begin
            step();
            checks++;
            if ({mode, sel, inc, dec} !== {e_mode, e_sel, e_inc, e_dec}) begin
                failures++;
                $display("FAIL settle k=%0d got=%b exp=%b", k, {mode, sel, inc, dec}, {e_mode, e_sel, e_inc, e_dec});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_btns(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
            checks++;
            if ({mode, sel, inc, dec} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs k=%0d got=%b exp=0000", k, {mode, sel, inc, dec});
            end
        end
        settle(20);
    endtask

    task automatic test_sel_clean();
        int n = 0;
        int first = -1;
        btn_sel = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            if (k == 21) btn_sel = 1'b0;
            step();
            checks++;
            if ({mode, sel, inc, dec} !== {e_mode, e_sel, e_inc, e_dec}) begin
                failures++;
                $display("FAIL sel_model k=%0d got=%b exp=%b", k, {mode, sel, inc, dec}, {e_mode, e_sel, e_inc, e_dec});
            end
            if (sel) begin
                n++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (n !== 1) begin failures++; $display("FAIL sel_count got=%0d exp=1", n); end
        checks++;
        if (first !== 7) begin failures++; $display("FAIL sel_edge got=%0d exp=7", first); end
        settle(15);
    endtask

    task automatic test_bounce();
        int n = 0;
        int first = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 12) btn_mode = (((k - 1) / 2) % 2 == 0);
            else if (k <= 30) btn_mode = 1'b1;
            else btn_mode = 1'b0;
            step();
            checks++;
            if ({mode, sel, inc, dec} !== {e_mode, e_sel, e_inc, e_dec}) begin
                failures++;
                $display("FAIL bounce_model k=%0d got=%b exp=%b", k, {mode, sel, inc, dec}, {e_mode, e_sel, e_inc, e_dec});
            end
            if (mode) begin
                n++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (n !== 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", n); end
        checks++;
        if (first !== 19) begin failures++; $display("FAIL bounce_edge got=%0d exp=19", first); end
        settle(15);
    endtask

    task automatic test_autorepeat();
        int edges[$];
        int ndec = 0;
        btn_up = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            if (k == 41) btn_up = 1'b0;
            step();
            checks++;
            if ({mode, sel, inc, dec} !== {e_mode, e_sel, e_inc, e_dec}) begin
                failures++;
                $display("FAIL repeat_model k=%0d got=%b exp=%b", k, {mode, sel, inc, dec}, {e_mode, e_sel, e_inc, e_dec});
            end
            if (inc) edges.push_back(k);
            if (dec) ndec++;
        end
        checks++;
        if (edges.size() !== 11) begin
            failures++; $display("FAIL repeat_count got=%0d exp=11", edges.size());
        end else begin
            checks++;
            if (edges[0] !== 7 || edges[1] !== 17 || edges[2] !== 20 || edges[10] !== 44) begin
                failures++;
                $display("FAIL repeat_edges got=%0d,%0d,%0d,%0d exp=7,17,20,44", edges[0], edges[1], edges[2], edges[10]);
            end
        end
        checks++;
        if (ndec !== 0) begin failures++; $display("FAIL repeat_dec got=%0d exp=0", ndec); end
        settle(20);
    endtask

    task automatic test_conflict();
        int n_early = 0;
        int n_locked = 0;
        int n_late = 0;
        bit got97 = 0;
        for (int k = 1; k <= 130; k++) begin
            btn_up   = (k <= 40) || (k >= 56 && k <= 70) || (k >= 91 && k <= 100);
            btn_down = (k >= 26 && k <= 70);
            step();
            checks++;
            if ({mode, sel, inc, dec} !== {e_mode, e_sel, e_inc, e_dec}) begin
                failures++;
                $display("FAIL conflict_model k=%0d got=%b exp=%b", k, {mode, sel, inc, dec}, {e_mode, e_sel, e_inc, e_dec});
            end
            if (k <= 31 && inc) n_early++;
            if (k >= 32 && k <= 96 && (inc || dec)) n_locked++;
            if (k == 97 && inc) got97 = 1;
            if (k > 97 && (inc || dec)) n_late++;
        end
        checks++;
        if (n_early !== 6) begin failures++; $display("FAIL conflict_before got=%0d exp=6", n_early); end
        checks++;
        if (n_locked !== 0) begin failures++; $display("FAIL conflict_locked got=%0d exp=0", n_locked); end
        checks++;
        if (got97 !== 1'b1) begin failures++; $display("FAIL conflict_repress got=%0d exp=1", got97); end
        checks++;
        if (n_late !== 0) begin failures++; $display("FAIL conflict_after got=%0d exp=0", n_late); end
        settle(20);
    endtask

    task automatic test_priority();
        int modes[$];
        int incs[$];
        set_btns(1, 0, 1, 0);
        for (int k = 1; k <= 60; k++) begin
            if (k == 31) set_btns(0, 0, 0, 0);
            step();
            checks++;
            if ({mode, sel, inc, dec} !== {e_mode, e_sel, e_inc, e_dec}) begin
                failures++;
                $display("FAIL prio_model k=%0d got=%b exp=%b", k, {mode, sel, inc, dec}, {e_mode, e_sel, e_inc, e_dec});
            end
            if (mode) modes.push_back(k);
            if (inc) incs.push_back(k);
        end
        checks++;
        if (modes.size() !== 1 || modes[0] !== 7) begin
            failures++; $display("FAIL prio_mode got_count=%0d exp_count=1 at edge 7", modes.size());
        end
        checks++;
        if (incs.size() !== 7 || incs[0] !== 17 || incs[1] !== 20) begin
            failures++; $display("FAIL prio_inc got_count=%0d exp_count=7 from edge 17", incs.size());
        end
        settle(20);
    endtask

    task automatic test_reset_midrepeat();
        int first_after = -1;
        btn_up = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            rst = (k >= 26 && k <= 28);
            if (k == 41) btn_up = 1'b0;
            step();
            checks++;
            if ({mode, sel, inc, dec} !== {e_mode, e_sel, e_inc, e_dec}) begin
                failures++;
                $display("FAIL rstrep_model k=%0d got=%b exp=%b", k, {mode, sel, inc, dec}, {e_mode, e_sel, e_inc, e_dec});
            end
            if (k >= 26 && k <= 28) begin
                checks++;
                if ({mode, sel, inc, dec} !== 4'b0000) begin
                    failures++; $display("FAIL rstrep_zero k=%0d got=%b exp=0000", k, {mode, sel, inc, dec});
                end
            end
            if (k >= 26 && inc && first_after < 0) first_after = k;
        end
        checks++;
        if (first_after !== 35) begin failures++; $display("FAIL rstrep_fresh got=%0d exp=35", first_after); end
        settle(20);
    endtask

    task automatic test_random();
        int hold;
        bit [3:0] b;
        for (int seg = 0; seg < 150; seg++) begin
            b = 4'($urandom_range(0, 15));
            set_btns(b[0], b[1], b[2], b[3] & ($urandom_range(0, 2) == 0));
            rst = ($urandom_range(0, 39) == 0);
            hold = rst ? $urandom_range(1, 3) : $urandom_range(1, 40);
            for (int h = 0; h < hold; h++) begin
                step();
                checks++;
                if ({mode, sel, inc, dec} !== {e_mode, e_sel, e_inc, e_dec}) begin
                    failures++;
                    $display("FAIL random_model seg=%0d got=%b exp=%b", seg, {mode, sel, inc, dec}, {e_mode, e_sel, e_inc, e_dec});
                end
                checks++;
                if ($countones({mode, sel, inc, dec}) > 1) begin
                    failures++;
                    $display("FAIL random_onehot seg=%0d got=%b exp=at most one set", seg, {mode, sel, inc, dec});
                end
            end
        end
        settle(30);
    endtask

    initial begin
        rst = 1'b1;
        set_btns(0, 0, 0, 0);
        test_reset();
        test_sel_clean();
        test_bounce();
        test_autorepeat();
        test_conflict();
        test_priority();
        test_reset_midrepeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
